// File: rtl/gray_rx_tracker.sv
// Receive-side gray-code tracker: converts sampled gray to binary, checks for hold/+1 steps,
// counts wrap-arounds and latches a sticky error on any illegal step.
module gray_rx_tracker #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LAP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_resync,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_binary,
  output logic             o_valid,
  output logic             o_wrap,
  output logic [LAP_W-1:0] o_laps,
  output logic             o_error
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_binary;
  logic             r_valid;
  logic             r_wrap;
  logic [LAP_W-1:0] r_laps;
  logic             r_error;

  logic [WIDTH-1:0] w_bn;
  logic [WIDTH-1:0] w_inc;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_bn = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_bn[i] = ^(i_gray >> i);
    end
  end

  assign w_inc = r_binary + WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_binary <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_laps   <= '0;
      r_error  <= 1'b0;
    end else if (i_resync) begin
      r_state  <= StIdle;
      r_binary <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_laps   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_en) begin
        unique case (r_state)
          StIdle: begin
            r_binary <= w_bn;
            r_valid  <= 1'b1;
            r_state  <= StTrack;
          end
          StTrack: begin
            if (w_bn == r_binary) begin
              r_binary <= r_binary;
            end else if (w_bn == w_inc) begin
              r_binary <= w_bn;
              if (w_bn == '0) begin
                r_wrap <= 1'b1;
                if (!(&r_laps)) r_laps <= r_laps + LAP_W'(1);
              end
            end else begin
              // Binary keeps the last good value; only Resync/Reset leave FAULT.
              r_error <= 1'b1;
              r_state <= StFault;
            end
          end
          StFault: r_state <= StFault;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_binary = r_binary;
  assign o_valid  = r_valid;
  assign o_wrap   = r_wrap;
  assign o_laps   = r_laps;
  assign o_error  = r_error;

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Scoreboard bench for gray_rx_tracker: a behavioural model queues expected outputs per edge,
// which are popped and compared one time unit after the edge.
module tb_gray_rx_tracker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       resync;
  logic [2:0] gray;

  logic [2:0] bin_a;
  logic       valid_a, wrap_a, err_a;
  logic [7:0] laps_a;
  logic [2:0] bin_b;
  logic       valid_b, wrap_b, err_b;
  logic [1:0] laps_b;

  gray_rx_tracker #(.WIDTH(3), .LAP_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_resync(resync), .i_gray(gray),
    .o_binary(bin_a), .o_valid(valid_a), .o_wrap(wrap_a), .o_laps(laps_a), .o_error(err_a)
  );

  gray_rx_tracker #(.WIDTH(3), .LAP_W(2)) dut_lap2 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_resync(resync), .i_gray(gray),
    .o_binary(bin_b), .o_valid(valid_b), .o_wrap(wrap_b), .o_laps(laps_b), .o_error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int valid;
    int wrap;
    int laps;
    int laps2;
    int err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model state: 0 idle, 1 track, 2 fault.
  int m_state, m_bin, m_valid, m_wrap, m_laps, m_laps2, m_err;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    return (g ^ (g >> 1) ^ (g >> 2)) & 7;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_bin = 0; m_valid = 0; m_wrap = 0;
    m_laps = 0; m_laps2 = 0; m_err = 0;
  endfunction

  function automatic void model_step(input int e, input int r, input int g);
    int bn;
    bn = g2b(g);
    if (r != 0) begin
      model_reset();
      return;
    end
    m_wrap = 0;
    if (e == 0) return;
    if (m_state == 0) begin
      m_bin = bn; m_valid = 1; m_state = 1;
    end else if (m_state == 1) begin
      if (bn == m_bin) begin
        // stall
      end else if (bn == (m_bin + 1) % 8) begin
        if (bn == 0) begin
          m_wrap = 1;
          if (m_laps < 255) m_laps++;
          if (m_laps2 < 3) m_laps2++;
        end
        m_bin = bn;
      end else begin
        m_err = 1; m_state = 2;
      end
    end
  endfunction

  task automatic compare_all(input string tag, input exp_t x);
    check({tag, ".binary"}, int'(bin_a), x.bin);
    check({tag, ".valid"}, int'(valid_a), x.valid);
    check({tag, ".wrap"}, int'(wrap_a), x.wrap);
    check({tag, ".laps"}, int'(laps_a), x.laps);
    check({tag, ".error"}, int'(err_a), x.err);
    check({tag, ".laps2"}, int'(laps_b), x.laps2);
    check({tag, ".wrap2"}, int'(wrap_b), x.wrap);
  endtask

  task automatic drive(input string tag, input logic e, input logic r, input logic [2:0] g);
    exp_t x;
    @(negedge clk);
    en = e; resync = r; gray = g;
    model_step(int'(e), int'(r), int'(g));
    x.bin = m_bin; x.valid = m_valid; x.wrap = m_wrap;
    x.laps = m_laps; x.laps2 = m_laps2; x.err = m_err;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      compare_all(tag, q.pop_front());
    end
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    exp_t x;
    @(negedge clk);
    en = 1'b0; resync = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    x.bin = 0; x.valid = 0; x.wrap = 0; x.laps = 0; x.laps2 = 0; x.err = 0;
    compare_all(tag, x);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  initial begin
    rst = 1'b1; en = 1'b0; resync = 1'b0; gray = 3'b000;
    model_reset();
    #1;
    begin
      exp_t x0;
      x0.bin = 0; x0.valid = 0; x0.wrap = 0; x0.laps = 0; x0.laps2 = 0; x0.err = 0;
      compare_all("reset", x0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Full lap: 0..7 then wrap to 0.
    for (int i = 0; i < 8; i++) drive("lap", 1'b1, 1'b0, 3'(seq[i]));
    drive("lap_wrap", 1'b1, 1'b0, 3'b000);
    drive("after_wrap", 1'b0, 1'b0, 3'b000);

    // Stall at Binary=2, then En low.
    drive("stall", 1'b1, 1'b0, 3'b001);
    for (int i = 0; i < 3; i++) drive("stall", 1'b1, 1'b0, 3'b011);
    drive("en_low", 1'b0, 1'b0, 3'b111);
    drive("en_low", 1'b0, 1'b0, 3'b100);

    // Illegal step 1 -> 3, then fault holds.
    async_reset("rst_pre_fault");
    drive("cap1", 1'b1, 1'b0, 3'b001);
    drive("illegal", 1'b1, 1'b0, 3'b010);
    drive("fault_hold", 1'b1, 1'b0, 3'b110);
    drive("fault_hold", 1'b1, 1'b0, 3'b111);

    // Resync out of fault and recapture at 4.
    drive("resync", 1'b0, 1'b1, 3'b000);
    drive("recap", 1'b1, 1'b0, 3'b110);
    drive("recap_step", 1'b1, 1'b0, 3'b111);

    // Async reset mid-sequence, then capture at 6.
    async_reset("async_rst");
    drive("post_rst", 1'b1, 1'b0, 3'b101);
    drive("post_rst_step", 1'b1, 1'b0, 3'b100);

    // Resync beats En on the same edge.
    drive("resync_en", 1'b1, 1'b1, 3'b011);

    // Five laps: LAP_W=2 instance saturates at 3.
    drive("laps_cap", 1'b1, 1'b0, 3'b000);
    for (int l = 0; l < 5; l++) begin
      for (int i = 1; i < 8; i++) drive("laps", 1'b1, 1'b0, 3'(seq[i]));
      drive("laps_wrap", 1'b1, 1'b0, 3'b000);
    end
    drive("laps_end", 1'b0, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
